rr_arbiter_4_code: RTL and testbench

- Four-way round-robin arbiter that sits directly upstream of the 2-to-4 decoder / 1-to-4 demultiplexer.
- It chooses one of four requesters and presents the winner as a 2-bit binary code, which drives the decoder select inputs (x1 = grant_code[1], x0 = grant_code[0]).
- It also drives a valid flag that gates the demultiplexed data.
- Grants are held until the owner releases or a hold timeout expires. Fairness is enforced by a rotating priority pointer.

---
 rtl/rr_arbiter_4_code.sv | 107 ++++++++++
 tb/tb_rr_arbiter_4_code.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4_code.sv
// Four-way round-robin arbiter producing a registered 2-bit grant code for a
// downstream 2-to-4 decoder, with a hold timeout and a forced idle gap between grants.
module rr_arbiter_4_code #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    output logic       grant_valid,
    output logic [1:0] grant_code,
    output logic       timeout,
    output logic       o_dbg_state
);

    // Output contract: grant_code is only meaningful while grant_valid = 1 and
    // never changes while grant_valid = 1; every grant is followed by at least
    // one grant_valid = 0 cycle. done is a release strobe honoured only in GRANT.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam bit         TIMEOUT_EN = (HOLD_MAX != 0);
    localparam logic [7:0] HOLD_LAST  = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_last;
    logic [1:0] w_next_last;
    logic [1:0] r_code;
    logic [1:0] w_next_code;
    logic [7:0] r_hold;
    logic [7:0] w_next_hold;
    logic       r_timeout;
    logic       w_next_timeout;

    logic [1:0] w_pick;
    logic [1:0] w_idx;
    logic       w_found;

    // Rotating-priority scan starting just after the last owner.
    always_comb begin
        w_pick  = r_last;
        w_idx   = 2'd0;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_last    = r_last;
        w_next_code    = r_code;
        w_next_hold    = r_hold;
        w_next_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next_state = ST_GRANT;
                    w_next_code  = w_pick;
                    w_next_hold  = 8'd0;
                end
            end
            ST_GRANT: begin
                if (done || !req[r_code]) begin
                    w_next_state = ST_IDLE;
                    w_next_last  = r_code;
                end else if (TIMEOUT_EN && (r_hold == HOLD_LAST)) begin
                    w_next_state   = ST_IDLE;
                    w_next_last    = r_code;
                    w_next_timeout = 1'b1;
                end else if (r_hold != 8'hFF) begin
                    w_next_hold = r_hold + 8'd1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_last    <= 2'b11;
            r_code    <= 2'b00;
            r_hold    <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_last    <= w_next_last;
            r_code    <= w_next_code;
            r_hold    <= w_next_hold;
            r_timeout <= w_next_timeout;
        end
    end

    assign grant_valid = (r_state == ST_GRANT);
    assign grant_code  = r_code;
    assign timeout     = r_timeout;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rr_arbiter_4_code.sv
// Scoreboard bench for rr_arbiter_4_code: two instances (HOLD_MAX = 8 and 0)
// share randomized and directed stimulus and are checked against a behavioural model.
module tb_rr_arbiter_4_code;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       done;

    logic       gv8, to8, st8;
    logic [1:0] gc8;
    logic       gv0, to0, st0;
    logic [1:0] gc0;

    always #5 clock = ~clock;

    rr_arbiter_4_code #(.HOLD_MAX(8)) u_dut8 (
        .clock(clock), .reset(reset), .req(req), .done(done),
        .grant_valid(gv8), .grant_code(gc8), .timeout(to8), .o_dbg_state(st8)
    );

    rr_arbiter_4_code #(.HOLD_MAX(0)) u_dut0 (
        .clock(clock), .reset(reset), .req(req), .done(done),
        .grant_valid(gv0), .grant_code(gc0), .timeout(to0), .o_dbg_state(st0)
    );

    // Model: owner = -1 when nobody holds the resource; held = cycles granted so far.
    typedef struct {
        int owner;
        int code;
        int last;
        int held;
        bit to;
    } model_t;

    model_t     m8, m0;
    logic [4:0] exp_q8[$];
    logic [4:0] exp_q0[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;

    function automatic model_t model_step(model_t m, int hold_max, bit rst, logic [3:0] rq, bit dn);
        model_t n;
        n    = m;
        n.to = 1'b0;
        if (rst) begin
            n.owner = -1;
            n.code  = 0;
            n.last  = 3;
            n.held  = 0;
        end else if (m.owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                int i;
                i = (m.last + k) % 4;
                if (rq[i] && n.owner < 0) begin
                    n.owner = i;
                    n.code  = i;
                    n.held  = 1;
                end
            end
        end else if (dn || !rq[m.owner]) begin
            n.last  = m.owner;
            n.owner = -1;
        end else if (hold_max != 0 && m.held == hold_max) begin
            n.last  = m.owner;
            n.owner = -1;
            n.to    = 1'b1;
        end else begin
            n.held = m.held + 1;
        end
        return n;
    endfunction

    // Packed as {grant_valid, debug state, grant_code, timeout}.
    function automatic logic [4:0] model_out(model_t m);
        logic       v;
        logic [1:0] c;
        v = (m.owner >= 0);
        c = 2'(m.code);
        return {v, v, c, m.to};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got {v,st,code,to}=%b expected=%b", name, cyc, act, exp);
    endtask

    task automatic cycle(input bit r, input logic [3:0] rq, input bit dn);
        reset = r;
        req   = rq;
        done  = dn;
        m8 = model_step(m8, 8, r, rq, dn);
        m0 = model_step(m0, 0, r, rq, dn);
        exp_q8.push_back(model_out(m8));
        exp_q0.push_back(model_out(m0));
        @(posedge clock);
        #2;
    endtask

    task automatic repeat_cycle(input int n, input logic [3:0] rq, input bit dn);
        for (int j = 0; j < n; j++) cycle(1'b0, rq, dn);
    endtask

    // Monitor: pops one expectation per instance after every edge that had stimulus.
    initial begin
        logic [4:0] e;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (exp_q8.size() > 0) begin
                e = exp_q8.pop_front();
                check("out_h8", {gv8, st8, gc8, to8}, e);
            end
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                check("out_h0", {gv0, st0, gc0, to0}, e);
            end
        end
    end

    initial begin
        m8 = '{owner: -1, code: 0, last: 3, held: 0, to: 1'b0};
        m0 = m8;
        reset = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;
        #2;

        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b1, 4'b0000, 1'b0);

        // All requesting: rotation 0,1,2,3,0 with timeouts on the HOLD_MAX=8 instance.
        repeat_cycle(46, 4'b1111, 1'b0);

        // Single requester released by done on its third grant cycle, then wrap to 0.
        cycle(1'b1, 4'b0000, 1'b0);
        repeat_cycle(3, 4'b0100, 1'b0);
        cycle(1'b0, 4'b0100, 1'b1);
        repeat_cycle(4, 4'b0101, 1'b0);

        // Grant to 1, req[3] raised mid-grant, then req[1] dropped.
        cycle(1'b1, 4'b0000, 1'b0);
        repeat_cycle(3, 4'b0010, 1'b0);
        repeat_cycle(2, 4'b1010, 1'b0);
        repeat_cycle(4, 4'b1000, 1'b0);

        // Reset in the middle of a grant, then only requester 3.
        cycle(1'b1, 4'b0000, 1'b0);
        repeat_cycle(7, 4'b1111, 1'b0);
        cycle(1'b1, 4'b1111, 1'b0);
        repeat_cycle(4, 4'b1000, 1'b0);

        // Long hold of requester 2, then done strobes while idle.
        cycle(1'b1, 4'b0000, 1'b0);
        repeat_cycle(300, 4'b0100, 1'b0);
        repeat_cycle(3, 4'b0000, 1'b1);
        repeat_cycle(2, 4'b0001, 1'b0);

        // Randomized traffic with occasional done and reset.
        for (int j = 0; j < 500; j++) begin
            cycle(($urandom_range(0, 63) == 0),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0));
        end

        #10;
        n_checks++;
        if (exp_q8.size() == 0 && exp_q0.size() == 0) n_pass++;
        else $display("FAIL drain got q8=%0d q0=%0d expected 0", exp_q8.size(), exp_q0.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
